ahb_lite_mem_slave: RTL



---
 rtl/ahb_lite_mem_slave.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite responder backed by a word-organised register memory, with wait-state
// insertion and the two-cycle ERROR response. Define AHB_LITE_SLV_PRIV_CHECK_EN to make the upper half privileged-only.
module ahb_lite_mem_slave #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int         DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  w_load;

  logic [DEPTH_LOG2-1:0] r_idx;
  logic [1:0]            r_lane;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [3:0]            r_prot;
  logic                  r_err;

  logic [31:0]           r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_size_bad;
  logic                  w_misalign;
  logic                  w_range_bad;
  logic                  w_priv_bad;
  logic                  w_err;
  logic [3:0]            w_be;
  logic                  w_unused;

  // Address-phase decode and error verdict
  assign w_accept    = HSEL && HREADY && HTRANS[1];
  assign w_size_bad  = (HSIZE > 3'd2);
  assign w_misalign  = ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign w_range_bad = |HADDR[31:DEPTH_LOG2+2];

`ifdef AHB_LITE_SLV_PRIV_CHECK_EN
  // Upper half of the memory (index MSB set) is reserved for privileged masters.
  assign w_priv_bad  = !HPROT[1] && HADDR[DEPTH_LOG2+1];
`else
  assign w_priv_bad  = 1'b0;
`endif

  assign w_err = w_size_bad || w_misalign || w_range_bad || w_priv_bad;

  // Bus attributes that are accepted but have no effect on this target.
  assign w_unused = ^{HBURST, HMASTLOCK, HTRANS[0], r_prot};

  // Next-state and wait counter
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_state_nxt = S_IDLE;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (w_err) begin
            w_state_nxt = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = WS_LOAD;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_write <= 1'b0;
      r_size  <= 3'd0;
      r_prot  <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_idx   <= HADDR[DEPTH_LOG2+1:2];
        r_lane  <= HADDR[1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
        r_prot  <= HPROT;
        r_err   <= w_err;
      end
    end
  end

  // Little-endian byte lanes for the registered size and address offset
  always_comb begin
    w_be = 4'b1111;
    case (r_size)
      3'd0:    w_be = 4'b0001 << r_lane;
      3'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // NOTE: the memory array has no reset; clearing it would cost a write port per word.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (r_state == S_DONE) && r_write && !r_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Bus response outputs
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = 32'd0;
    case (r_state)
      S_WAIT: HREADYOUT = 1'b0;
      S_DONE: begin
        if (!r_write) begin
          HRDATA = r_mem[r_idx];
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

endmodule
